// File: rtl/uart_tx_fifo_cfg_pkg.sv
// uart_tx_fifo_cfg_pkg
//   Shared definitions for the configurable UART transmitter: parity-mode
//   codes, transmitter FSM states and small helpers for frame setup.
`timescale 1ns/1ps
package uart_tx_fifo_cfg_pkg;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4,
    ST_GUARD = 3'd5,
    ST_BREAK = 3'd6
  } tx_state_e;

  localparam logic [3:0] MIN_DATA_BITS = 4'd5;

  // Codes 5..7 are reserved and behave as "no parity".
  function automatic parity_e decode_parity(input logic [2:0] code);
    parity_e mode;
    case (code)
      3'd1:    mode = PAR_EVEN;
      3'd2:    mode = PAR_ODD;
      3'd3:    mode = PAR_MARK;
      3'd4:    mode = PAR_SPACE;
      default: mode = PAR_NONE;
    endcase
    return mode;
  endfunction

  function automatic logic [3:0] clamp_dbits(input logic [3:0] req,
                                             input logic [3:0] max_bits);
    logic [3:0] n;
    if (req < MIN_DATA_BITS)  n = MIN_DATA_BITS;
    else if (req > max_bits)  n = max_bits;
    else                      n = req;
    return n;
  endfunction

  function automatic logic parity_bit(input parity_e mode, input logic data_xor);
    logic p;
    case (mode)
      PAR_EVEN: p = data_xor;
      PAR_ODD:  p = ~data_xor;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_cfg_sync_fifo.sv
// uart_tx_sync_fifo
//   Single-clock FIFO. Push is ignored when full, pop is ignored when empty;
//   push and pop on the same edge both take effect.
//   Ports: clk, rst_n (async, active low), push_i/data_i (write side),
//          pop_i/data_o (read side, data_o shows the head word),
//          full_o, empty_o, level_o (words held).
`timescale 1ns/1ps
module uart_tx_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// uart_tx_fifo_cfg
//   Runtime-configurable UART transmitter fed by a small input FIFO.
//   Frame format (divisor, data bits, parity, stop bits, guard time) is
//   captured per frame when the word leaves the FIFO.
//   Ports: clk, rst_n (async, active low)
//          s_data/s_valid/s_ready : word input handshake
//          cfg_div/cfg_dbits/cfg_parity/cfg_stop2/cfg_guard : frame format
//          brk        : line break request (level)
//          txd        : serial line, idle high
//          busy       : frame, guard or break in progress
//          frame_done : one-cycle pulse at the end of the last stop bit
//          fifo_level : words waiting in the FIFO
`timescale 1ns/1ps
module uart_tx_fifo_cfg
  import uart_tx_fifo_cfg_pkg::*;
#(
  parameter int MAX_DATA_BITS = 9,
  parameter int DIV_WIDTH     = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [MAX_DATA_BITS-1:0]      s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DIV_WIDTH-1:0]          cfg_div,
  input  logic [3:0]                    cfg_dbits,
  input  logic [2:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic [1:0]                    cfg_guard,
  input  logic                          brk,
  output logic                          txd,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  logic [MAX_DATA_BITS-1:0] fifo_rdata;
  logic                     fifo_full, fifo_empty, fifo_pop;

  uart_tx_sync_fifo #(
    .WIDTH (MAX_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (s_valid),
    .data_i  (s_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign s_ready = !fifo_full;

  tx_state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]     cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]     div_q, div_d;
  logic [3:0]               dbits_q, dbits_d;
  logic                     par_en_q, par_en_d;
  logic                     par_val_q, par_val_d;
  logic                     stop2_q, stop2_d;
  logic [1:0]               guard_q, guard_d;
  logic [MAX_DATA_BITS-1:0] shreg_q, shreg_d;
  logic [3:0]               bit_idx_q, bit_idx_d;
  logic                     txd_q, txd_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  // Frame setup values derived from the live config and FIFO head word.
  logic [3:0]               dbits_eff;
  logic [MAX_DATA_BITS-1:0] used_mask;
  parity_e                  par_mode;
  logic                     bit_end;

  always_comb begin
    dbits_eff = clamp_dbits(cfg_dbits, 4'(MAX_DATA_BITS));
    par_mode  = decode_parity(cfg_parity);
    used_mask = '0;
    for (int unsigned i = 0; i < MAX_DATA_BITS; i++) begin
      used_mask[i] = (i < 32'(dbits_eff));
    end
  end

  assign bit_end = (cnt_q == div_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      dbits_q   <= MIN_DATA_BITS;
      par_en_q  <= 1'b0;
      par_val_q <= 1'b0;
      stop2_q   <= 1'b0;
      guard_q   <= '0;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      dbits_q   <= dbits_d;
      par_en_q  <= par_en_d;
      par_val_q <= par_val_d;
      stop2_q   <= stop2_d;
      guard_q   <= guard_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Every transition out of a timed state happens on bit_end, where the
  // counter wraps to zero anyway; IDLE and BREAK hold it at zero so the
  // next timed state always starts from a cleared count.
  always_comb begin
    state_d   = state_q;
    cnt_d     = bit_end ? '0 : cnt_q + 1'b1;
    div_d     = div_q;
    dbits_d   = dbits_q;
    par_en_d  = par_en_q;
    par_val_d = par_val_q;
    stop2_d   = stop2_q;
    guard_d   = guard_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    txd_d     = txd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    fifo_pop  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (brk) begin
          state_d = ST_BREAK;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
        end else if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          div_d     = cfg_div;
          dbits_d   = dbits_eff;
          par_en_d  = (par_mode != PAR_NONE);
          par_val_d = parity_bit(par_mode, ^(fifo_rdata & used_mask));
          stop2_d   = cfg_stop2;
          guard_d   = cfg_guard;
          shreg_d   = fifo_rdata;
          state_d   = ST_START;
          txd_d     = 1'b0;
          busy_d    = 1'b1;
        end
      end

      ST_START: begin
        if (bit_end) begin
          txd_d     = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == dbits_q - 4'd1) begin
            bit_idx_d = '0;
            if (par_en_q) begin
              txd_d   = par_val_q;
              state_d = ST_PAR;
            end else begin
              txd_d   = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            txd_d     = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end

      ST_PAR: begin
        if (bit_end) begin
          txd_d     = 1'b1;
          bit_idx_d = '0;
          state_d   = ST_STOP;
        end
      end

      ST_STOP: begin
        if (bit_end) begin
          if (bit_idx_q == {3'b000, stop2_q}) begin
            done_d    = 1'b1;
            bit_idx_d = '0;
            if (guard_q != 2'd0) begin
              state_d = ST_GUARD;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end

      ST_GUARD: begin
        txd_d = 1'b1;
        if (bit_end) begin
          if (bit_idx_q == {2'b00, guard_q - 2'd1}) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end

      ST_BREAK: begin
        cnt_d  = '0;
        txd_d  = 1'b0;
        busy_d = 1'b1;
        if (!brk) begin
          // Post-break recovery reuses GUARD with a forced single bit time,
          // timed by the divisor in force at release.
          txd_d     = 1'b1;
          div_d     = cfg_div;
          guard_d   = 2'd1;
          bit_idx_d = '0;
          state_d   = ST_GUARD;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign txd        = txd_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo_cfg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] cfg_div = 16'd3;
  logic [3:0]  cfg_dbits = 4'd8;
  logic [2:0]  cfg_parity = 3'd0;
  logic        cfg_stop2 = 1'b0;
  logic [1:0]  cfg_guard = 2'd0;
  logic        brk = 1'b0;
  logic        txd, busy, frame_done;
  logic [2:0]  fifo_level;

  int checks = 0;
  int passed = 0;

  uart_tx_fifo_cfg #(
    .MAX_DATA_BITS (9),
    .DIV_WIDTH     (16),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .cfg_div    (cfg_div),
    .cfg_dbits  (cfg_dbits),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .cfg_guard  (cfg_guard),
    .brk        (brk),
    .txd        (txd),
    .busy       (busy),
    .frame_done (frame_done),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic set_cfg(input int div, input int dbits, input int par,
                         input bit stop2, input int guard);
    cfg_div    = 16'(div);
    cfg_dbits  = 4'(dbits);
    cfg_parity = 3'(par);
    cfg_stop2  = stop2;
    cfg_guard  = 2'(guard);
  endtask

  // One-cycle push; returns at the negedge after the accepting edge.
  task automatic push_word(input logic [8:0] w);
    @(negedge clk);
    s_data  = w;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Waits for a start bit, then checks every clock of every bit of the
  // expected frame, then the frame_done pulse and busy level right after.
  // par < 0 means no parity bit. waited = extra clocks before start seen.
  task automatic check_frame(input string name, input int div, input logic [8:0] data,
                             input int nd, input int par, input bit stop2,
                             input bit exp_busy, output int waited);
    logic exp_q[$];
    int   d;
    bit   bad;
    d = div + 1;
    exp_q.push_back(1'b0);
    for (int i = 0; i < nd; i++) exp_q.push_back(data[i]);
    if (par >= 0) exp_q.push_back(par[0]);
    exp_q.push_back(1'b1);
    if (stop2) exp_q.push_back(1'b1);
    waited = 0;
    @(negedge clk);
    while (txd !== 1'b0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (txd !== 1'b0) begin
      $display("FAIL %s start: txd=%b after %0d clocks, required 0", name, txd, waited);
      return;
    end
    passed++;
    foreach (exp_q[b]) begin
      bad = 1'b0;
      for (int k = 0; k < d; k++) begin
        if (b != 0 || k != 0) @(negedge clk);
        if (txd !== exp_q[b]) bad = 1'b1;
      end
      checks++;
      if (bad) $display("FAIL %s bit%0d: txd=%b, required %b for %0d clocks",
                        name, b, txd, exp_q[b], d);
      else passed++;
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b1 || busy !== exp_busy)
      $display("FAIL %s end: frame_done=%b busy=%b, required 1 and %b",
               name, frame_done, busy, exp_busy);
    else passed++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (txd !== 1'b1 || s_ready !== 1'b1 || busy !== 1'b0 ||
        frame_done !== 1'b0 || fifo_level !== 3'd0)
      $display("FAIL reset: txd=%b s_ready=%b busy=%b done=%b level=%0d, required 1 1 0 0 0",
               txd, s_ready, busy, frame_done, fifo_level);
    else passed++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_8n1();
    int  w;
    bit  ok;
    set_cfg(3, 8, 0, 1'b0, 0);
    push_word(9'h055);
    check_frame("8N1_55", 3, 9'h055, 8, -1, 1'b0, 1'b0, w);
    checks++;
    if (w !== 0) $display("FAIL latency: start after %0d extra clocks, required 0", w);
    else passed++;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) $display("FAIL idle_after: txd=%b busy=%b done=%b, required 1 0 0",
                      txd, busy, frame_done);
    else passed++;
  endtask

  task automatic test_parity();
    int w;
    // 0x41 in 7 bits: 1000001, two ones
    set_cfg(1, 7, 1, 1'b1, 0);
    push_word(9'h041);
    check_frame("7E2_41", 1, 9'h041, 7, 0, 1'b1, 1'b0, w);
    set_cfg(1, 7, 2, 1'b1, 0);
    push_word(9'h041);
    check_frame("7O2_41", 1, 9'h041, 7, 1, 1'b1, 1'b0, w);
    // nine ones: XOR = 1, odd -> 0
    set_cfg(1, 9, 2, 1'b0, 0);
    push_word(9'h1FF);
    check_frame("9O1_1FF", 1, 9'h1FF, 9, 0, 1'b0, 1'b0, w);
    set_cfg(1, 8, 3, 1'b0, 0);
    push_word(9'h055);
    check_frame("8M1_55", 1, 9'h055, 8, 1, 1'b0, 1'b0, w);
    set_cfg(1, 8, 4, 1'b0, 0);
    push_word(9'h1D5);
    check_frame("8S1_D5", 1, 9'h1D5, 8, 0, 1'b0, 1'b0, w);
    set_cfg(1, 8, 6, 1'b0, 0);
    push_word(9'h055);
    check_frame("8_par6_none", 1, 9'h055, 8, -1, 1'b0, 1'b0, w);
  endtask

  task automatic test_dbits_clamp();
    int w;
    set_cfg(1, 3, 0, 1'b0, 0);
    push_word(9'h007);
    check_frame("dbits3_as5", 1, 9'h007, 5, -1, 1'b0, 1'b0, w);
    set_cfg(1, 12, 0, 1'b0, 0);
    push_word(9'h0FF);
    check_frame("dbits12_as9", 1, 9'h0FF, 9, -1, 1'b0, 1'b0, w);
  endtask

  task automatic test_guard();
    int w, hi;
    bit ok;
    set_cfg(1, 8, 0, 1'b0, 2);
    push_word(9'h0A5);
    check_frame("guard2", 1, 9'h0A5, 8, -1, 1'b0, 1'b1, w);
    hi = 0;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      hi++;
      if (txd !== 1'b1) ok = 1'b0;
    end
    // two guard bits of 2 clocks; the first clock was seen with frame_done
    checks++;
    if (hi != 3 || !ok) $display("FAIL guard_len: busy high %0d more clocks (txd ok=%b), required 3 (1)",
                                 hi, ok);
    else passed++;
    set_cfg(1, 8, 0, 1'b0, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [8:0] words [6];
    int         idx, cyc, acc6, w;
    bit         rdy;
    words[0] = 9'h011; words[1] = 9'h022; words[2] = 9'h033;
    words[3] = 9'h044; words[4] = 9'h055; words[5] = 9'h066;
    set_cfg(15, 8, 0, 1'b0, 0);
    @(negedge clk);
    fork
      begin
        idx = 0;
        cyc = 0;
        acc6 = -1;
        s_data  = words[0];
        s_valid = 1'b1;
        while (idx < 6 && cyc < 400) begin
          rdy = s_ready;
          @(posedge clk);
          cyc++;
          if (rdy) begin
            idx++;
            if (idx == 6) acc6 = cyc;
          end
          @(negedge clk);
          if (cyc == 5) begin
            checks++;
            if (s_ready !== 1'b0 || fifo_level !== 3'd4 || idx != 5)
              $display("FAIL fifo_full: s_ready=%b level=%0d accepted=%0d, required 0 4 5",
                       s_ready, fifo_level, idx);
            else passed++;
          end
          if (idx < 6) s_data = words[idx];
          else s_valid = 1'b0;
        end
        s_valid = 1'b0;
        // frame 1 popped at edge 2, ends at 162, frame 2 popped at 163
        checks++;
        if (acc6 != 164) $display("FAIL sixth_accept: edge %0d, required 164", acc6);
        else passed++;
      end
      begin
        for (int f = 0; f < 6; f++) begin
          check_frame($sformatf("b2b_f%0d", f), 15, words[f], 8, -1, 1'b0, 1'b0, w);
          if (f > 0) begin
            checks++;
            if (w != 0) $display("FAIL b2b_gap%0d: %0d extra idle clocks, required 0", f, w);
            else passed++;
          end
        end
      end
    join
  endtask

  task automatic test_break();
    int w;
    bit ok;
    set_cfg(7, 8, 0, 1'b0, 0);
    push_word(9'h0A5);
    fork
      check_frame("brk_frame", 7, 9'h0A5, 8, -1, 1'b0, 1'b0, w);
      begin
        repeat (20) @(negedge clk);
        s_data  = 9'h03C;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        repeat (10) @(negedge clk);
        brk = 1'b1;
      end
    join
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (txd !== 1'b0 || busy !== 1'b1 || fifo_level !== 3'd1) ok = 1'b0;
    end
    checks++;
    if (!ok) $display("FAIL break_hold: txd=%b busy=%b level=%0d, required 0 1 1",
                      txd, busy, fifo_level);
    else passed++;
    brk = 1'b0;
    // one guard bit time (8 clocks) plus the single IDLE clock
    ok = 1'b1;
    repeat (9) begin
      @(negedge clk);
      if (txd !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok) $display("FAIL break_release: txd=%b during recovery, required 1", txd);
    else passed++;
    check_frame("after_brk", 7, 9'h03C, 8, -1, 1'b0, 1'b0, w);
    checks++;
    if (w != 0) $display("FAIL break_gap: start %0d clocks late, required 0", w);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int w;
    bit ok;
    set_cfg(3, 8, 0, 1'b0, 0);
    repeat (4) push_word(9'h000);
    checks++;
    if (fifo_level !== 3'd3) $display("FAIL rst_prelevel: level=%0d, required 3", fifo_level);
    else passed++;
    repeat (4) @(negedge clk);
    checks++;
    if (txd !== 1'b0 || busy !== 1'b1) $display("FAIL rst_predata: txd=%b busy=%b, required 0 1", txd, busy);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1 || fifo_level !== 3'd0 || busy !== 1'b0 || s_ready !== 1'b1)
      $display("FAIL rst_async: txd=%b level=%0d busy=%b s_ready=%b, required 1 0 0 1",
               txd, fifo_level, busy, s_ready);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) $display("FAIL rst_quiet: txd=%b busy=%b, required 1 0", txd, busy);
    else passed++;
    push_word(9'h0A3);
    check_frame("after_rst", 3, 9'h0A3, 8, -1, 1'b0, 1'b0, w);
  endtask

  task automatic test_cfg_change();
    int w;
    set_cfg(1, 8, 0, 1'b0, 0);
    push_word(9'h096);
    fork
      check_frame("cfg_old_div", 1, 9'h096, 8, -1, 1'b0, 1'b0, w);
      begin
        repeat (6) @(negedge clk);
        cfg_div = 16'd5;
      end
    join
    push_word(9'h069);
    check_frame("cfg_new_div", 5, 9'h069, 8, -1, 1'b0, 1'b0, w);
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_dbits_clamp();
    test_guard();
    test_back_to_back();
    test_break();
    test_reset_mid();
    test_cfg_change();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
